seg_hazard_scoreboard: RTL and testbench

- Sits directly downstream of the decode-stage segment address/dependency logic.
- Takes each decoded instruction's segment read selects (seg1/seg2/seg3 plus needed flags) and its segment write (dseg/ld_seg).
- Stalls decode while any needed segment register has an older, uncompleted write in flight.
- Registers accepted instructions into a one-entry valid/ready pipeline slot toward register read, and tracks in-flight segment writes with per-register counters retired by writeback.

---
 rtl/seg_hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_seg_hazard_scoreboard.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_hazard_scoreboard.sv
// Segment-register hazard scoreboard: stalls decode on pending segment writes and
// hands accepted instructions to register read through a one-entry output slot.
module seg_hazard_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int NUM_SEG = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               seg1_needed,
  input  logic               seg2_needed,
  input  logic               seg3_needed,
  input  logic [2:0]         seg1,
  input  logic [2:0]         seg2,
  input  logic [2:0]         seg3,
  input  logic               ld_seg,
  input  logic [2:0]         dseg,
  output logic               stall,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_seg1,
  output logic [2:0]         out_seg2,
  output logic [2:0]         out_seg3,
  output logic [2:0]         out_seg_needed,
  output logic [2:0]         out_dseg,
  output logic               out_ld_seg,
  input  logic               wb_seg_valid,
  input  logic [2:0]         wb_seg,
  output logic [NUM_SEG-1:0] pend_mask
);

  logic [CNT_W-1:0]   cnt_q [NUM_SEG];
  logic [CNT_W-1:0]   cnt_d [NUM_SEG];
  logic [NUM_SEG-1:0] pend;
  logic [NUM_SEG-1:0] inc_vec;
  logic [NUM_SEG-1:0] dec_vec;
  logic               hazard;
  logic               sat;
  logic               slot_free;
  logic               accept;

  logic               out_valid_q, out_valid_d;
  logic [2:0]         out_seg1_q, out_seg2_q, out_seg3_q;
  logic [2:0]         out_need_q, out_dseg_q;
  logic               out_ld_q;

  always_comb begin
    for (int i = 0; i < NUM_SEG; i++) begin
      pend[i] = |cnt_q[i];
    end
  end

  // Hazards look only at registered counters; a same-cycle writeback clears next cycle.
  assign hazard    = (seg1_needed & pend[seg1]) | (seg2_needed & pend[seg2]) |
                     (seg3_needed & pend[seg3]);
  assign sat       = ld_seg & (&cnt_q[dseg]);
  assign slot_free = ~out_valid_q | out_ready;
  assign accept    = in_valid & ~hazard & ~sat & slot_free & ~flush;
  assign stall     = in_valid & ~accept;

  always_comb begin
    for (int i = 0; i < NUM_SEG; i++) begin
      inc_vec[i] = accept & ld_seg & (dseg == 3'(i));
      dec_vec[i] = wb_seg_valid & (wb_seg == 3'(i)) & pend[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SEG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_vec[i] & ~dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_vec[i] & ~inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        cnt_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_seg1_q  <= '0;
      out_seg2_q  <= '0;
      out_seg3_q  <= '0;
      out_need_q  <= '0;
      out_dseg_q  <= '0;
      out_ld_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      out_valid_q <= out_valid_d;
      if (accept) begin
        out_seg1_q <= seg1;
        out_seg2_q <= seg2;
        out_seg3_q <= seg3;
        out_need_q <= {seg3_needed, seg2_needed, seg1_needed};
        out_dseg_q <= dseg;
        out_ld_q   <= ld_seg;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_seg1       = out_seg1_q;
  assign out_seg2       = out_seg2_q;
  assign out_seg3       = out_seg3_q;
  assign out_seg_needed = out_need_q;
  assign out_dseg       = out_dseg_q;
  assign out_ld_seg     = out_ld_q;
  assign pend_mask      = pend;

endmodule

// File: tb/tb_seg_hazard_scoreboard.sv
// Bench for seg_hazard_scoreboard: directed scenarios plus randomized traffic
// compared against an integer-count reference model.
module tb_seg_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid;
  logic       seg1_needed, seg2_needed, seg3_needed;
  logic [2:0] seg1, seg2, seg3, dseg, wb_seg;
  logic       ld_seg, out_ready, wb_seg_valid;
  logic       stall, out_valid, out_ld_seg;
  logic [2:0] out_seg1, out_seg2, out_seg3, out_seg_needed, out_dseg;
  logic [7:0] pend_mask;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_hazard_scoreboard #(.CNT_W(2), .NUM_SEG(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .seg1_needed(seg1_needed), .seg2_needed(seg2_needed), .seg3_needed(seg3_needed),
    .seg1(seg1), .seg2(seg2), .seg3(seg3), .ld_seg(ld_seg), .dseg(dseg),
    .stall(stall), .out_valid(out_valid), .out_ready(out_ready),
    .out_seg1(out_seg1), .out_seg2(out_seg2), .out_seg3(out_seg3),
    .out_seg_needed(out_seg_needed), .out_dseg(out_dseg), .out_ld_seg(out_ld_seg),
    .wb_seg_valid(wb_seg_valid), .wb_seg(wb_seg), .pend_mask(pend_mask)
  );

  logic [24:0] obs;
  assign obs = {out_valid, out_seg1, out_seg2, out_seg3, out_seg_needed,
                out_dseg, out_ld_seg, pend_mask};

  // Reference model: plain pending-write counts and a copy of the output slot.
  int         m_cnt [8];
  logic       m_ov, m_ld;
  logic [2:0] m_s1, m_s2, m_s3, m_need, m_dseg;

  function automatic logic [7:0] m_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  function automatic logic [24:0] m_bundle();
    return {m_ov, m_s1, m_s2, m_s3, m_need, m_dseg, m_ld, m_pend()};
  endfunction

  function automatic logic m_accept();
    logic haz;
    haz = (seg1_needed && m_cnt[seg1] > 0) || (seg2_needed && m_cnt[seg2] > 0) ||
          (seg3_needed && m_cnt[seg3] > 0);
    return in_valid && !haz && !(ld_seg && m_cnt[dseg] == 3) &&
           (!m_ov || out_ready) && !flush;
  endfunction

  function automatic logic m_stall();
    return in_valid && !m_accept();
  endfunction

  task automatic m_edge();
    logic acc, dec_ok;
    acc = m_accept();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_ov = 0; m_ld = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_need = 0; m_dseg = 0;
    end else if (flush) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_ov = 0;
    end else begin
      dec_ok = wb_seg_valid && m_cnt[wb_seg] > 0;
      if (acc && ld_seg) m_cnt[dseg] = m_cnt[dseg] + 1;
      if (dec_ok) m_cnt[wb_seg] = m_cnt[wb_seg] - 1;
      if (acc) begin
        m_ov = 1; m_s1 = seg1; m_s2 = seg2; m_s3 = seg3;
        m_need = {seg3_needed, seg2_needed, seg1_needed};
        m_dseg = dseg; m_ld = ld_seg;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; ld_seg = 0; dseg = 0;
    seg1_needed = 0; seg2_needed = 0; seg3_needed = 0;
    seg1 = 0; seg2 = 0; seg3 = 0;
    wb_seg_valid = 0; wb_seg = 0; out_ready = 1;
  endtask

  task automatic clear_state();
    idle(); rst = 1; tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; seg1 = 3'($urandom_range(0, 7)); wb_seg_valid = 1; wb_seg = 3'($urandom_range(0, 7));
    tick(); tick();
    idle(); #1;
    n_tests++;
    if (obs !== 25'h0) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", obs, 25'h0);
    end
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall got=%b want=0", stall);
    end
  endtask

  task automatic test_write_read_hazard();
    clear_state();
    in_valid = 1; ld_seg = 1; dseg = 3; #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL wr_first_stall got=%b want=0", stall); end
    tick();
    n_tests++;
    if (pend_mask !== 8'h08 || out_valid !== 1'b1 || out_dseg !== 3'd3) begin
      n_fail++; $display("FAIL wr_pend got pend=%h ov=%b dseg=%0d want pend=08 ov=1 dseg=3",
                         pend_mask, out_valid, out_dseg);
    end
    ld_seg = 0; dseg = 0; seg1 = 3; seg1_needed = 1; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL wr_hazard_stall got=%b want=1", stall); end
    tick();
    wb_seg_valid = 1; wb_seg = 3; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL wr_wb_same_cycle got=%b want=1", stall); end
    tick();
    wb_seg_valid = 0; #1;
    n_tests++;
    if (stall !== 1'b0 || pend_mask !== 8'h00) begin
      n_fail++; $display("FAIL wr_released got stall=%b pend=%h want stall=0 pend=00", stall, pend_mask);
    end
    tick();
    in_valid = 0; #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_seg1 !== 3'd3 || obs !== m_bundle()) begin
      n_fail++; $display("FAIL wr_out_seg1 got=%h want=%h", obs, m_bundle());
    end
  endtask

  task automatic test_saturation();
    clear_state();
    in_valid = 1; ld_seg = 1; dseg = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_fill%0d got stall=%b want=0", k, stall); end
      tick();
    end
    #1;
    n_tests++;
    if (stall !== 1'b1 || pend_mask !== 8'h01) begin
      n_fail++; $display("FAIL sat_full got stall=%b pend=%h want stall=1 pend=01", stall, pend_mask);
    end
    wb_seg_valid = 1; wb_seg = 0; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_wb_same got=%b want=1", stall); end
    tick();
    wb_seg_valid = 0; #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL sat_after_wb got=%b want=0", stall); end
    tick();
    in_valid = 0; #1;
    n_tests++;
    if (obs !== m_bundle() || m_cnt[0] != 3) begin
      n_fail++; $display("FAIL sat_refill got=%h want=%h", obs, m_bundle());
    end
  endtask

  task automatic test_inc_dec();
    clear_state();
    in_valid = 1; ld_seg = 1; dseg = 2; tick();
    wb_seg_valid = 1; wb_seg = 2; #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL incdec_stall got=%b want=0", stall); end
    tick();
    in_valid = 0; ld_seg = 0; wb_seg_valid = 0; #1;
    n_tests++;
    if (pend_mask !== 8'h04) begin n_fail++; $display("FAIL incdec_pend got=%h want=04", pend_mask); end
    wb_seg_valid = 1; wb_seg = 2; tick();
    wb_seg_valid = 0; #1;
    n_tests++;
    if (pend_mask !== 8'h00) begin n_fail++; $display("FAIL incdec_count1 got=%h want=00", pend_mask); end
  endtask

  task automatic test_backpressure();
    clear_state();
    out_ready = 0; in_valid = 1; seg1 = 1; seg2 = 2; seg3 = 4; seg2_needed = 1;
    tick();
    seg1 = 5; seg2 = 6; seg3 = 7; seg2_needed = 0; seg3_needed = 1; ld_seg = 1; dseg = 4; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL bp_stall got=%b want=1", stall); end
    tick();
    n_tests++;
    if (obs !== {1'b1, 3'd1, 3'd2, 3'd4, 3'b010, 3'd0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL bp_hold got=%h want=%h", obs,
                         {1'b1, 3'd1, 3'd2, 3'd4, 3'b010, 3'd0, 1'b0, 8'h00});
    end
    out_ready = 1; #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b want=0", stall); end
    tick();
    in_valid = 0; ld_seg = 0; out_ready = 0; #1;
    n_tests++;
    if (obs !== {1'b1, 3'd5, 3'd6, 3'd7, 3'b100, 3'd4, 1'b1, 8'h10}) begin
      n_fail++; $display("FAIL bp_new got=%h want=%h", obs,
                         {1'b1, 3'd5, 3'd6, 3'd7, 3'b100, 3'd4, 1'b1, 8'h10});
    end
  endtask

  task automatic test_flush();
    clear_state();
    in_valid = 1; ld_seg = 1; dseg = 3; tick();
    dseg = 5; tick();
    in_valid = 0; ld_seg = 0; out_ready = 0; #1;
    n_tests++;
    if (pend_mask !== 8'h28 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL fl_setup got pend=%h ov=%b want pend=28 ov=1", pend_mask, out_valid);
    end
    flush = 1; in_valid = 1; wb_seg_valid = 1; wb_seg = 5; #1;
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL fl_stall got=%b want=1", stall); end
    tick();
    flush = 0; in_valid = 0; #1;
    n_tests++;
    if (pend_mask !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fl_clear got pend=%h ov=%b want pend=00 ov=0", pend_mask, out_valid);
    end
    tick();
    wb_seg_valid = 0; #1;
    n_tests++;
    if (pend_mask !== 8'h00) begin n_fail++; $display("FAIL fl_underflow got=%h want=00", pend_mask); end
  endtask

  task automatic test_reset_midop();
    clear_state();
    out_ready = 0; in_valid = 1; ld_seg = 1; dseg = 1; seg1 = 6; tick();
    in_valid = 0; rst = 1; tick();
    rst = 0; #1;
    n_tests++;
    if (obs !== 25'h0) begin n_fail++; $display("FAIL rst_midop got=%h want=%h", obs, 25'h0); end
  endtask

  task automatic test_random();
    clear_state();
    for (int c = 0; c < 400; c++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      seg1         = 3'($urandom_range(0, 7));
      seg2         = 3'($urandom_range(0, 7));
      seg3         = 3'($urandom_range(0, 7));
      seg1_needed  = 1'($urandom_range(0, 1));
      seg2_needed  = 1'($urandom_range(0, 1));
      seg3_needed  = ($urandom_range(0, 3) == 0);
      ld_seg       = 1'($urandom_range(0, 1));
      dseg         = 3'($urandom_range(0, 3));
      wb_seg_valid = ($urandom_range(0, 2) == 0);
      wb_seg       = 3'($urandom_range(0, 3));
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 40) == 0);
      #1;
      n_tests++;
      if (stall !== m_stall()) begin
        n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b want=%b", c, stall, m_stall());
      end
      tick();
      n_tests++;
      if (obs !== m_bundle()) begin
        n_fail++; $display("FAIL rnd_outputs cyc=%0d got=%h want=%h", c, obs, m_bundle());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    m_ov = 0; m_ld = 0; m_s1 = 0; m_s2 = 0; m_s3 = 0; m_need = 0; m_dseg = 0;
    #2;
    test_reset();
    test_write_read_hazard();
    test_saturation();
    test_inc_dec();
    test_backpressure();
    test_flush();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
